pulse_monitor: RTL and testbench
================================

Name: pulse_monitor

Overview:
Downstream consumer of the one-hot state outputs (IDLE, PRE_PULSE, PULSE) of the pulse-transition FSM.
- Registers those three lines and checks that the sequence IDLE -> PRE_PULSE -> PULSE -> IDLE is legal.
- Measures the width of each PULSE phase and counts completed pulses.
- Reports sequencing faults as a sticky error with a first-error code for bench/debug readback.

Parameters:
CNT_W, 16, width of completed-pulse counter PULSE_CNT
WIDTH_W, 8, width of pulse-width measurement LAST_WIDTH
MAX_PULSE, 4, max legal PULSE width in cycles (used only with optional feature)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
IDLE  input  1  upstream FSM in IDLE state
PRE_PULSE  input  1  upstream FSM in PRE_PULSE state
PULSE  input  1  upstream FSM in PULSE state
CLR_ERR  input  1  clears SEQ_ERR/ERR_CODE/TOO_LONG
PULSE_CNT  output  CNT_W  number of completed pulses, wraps
LAST_WIDTH  output  WIDTH_W  width in cycles of most recent completed pulse
WIDTH_VALID  output  1  one-cycle strobe: LAST_WIDTH just updated
SEQ_ERR  output  1  sticky sequencing error
ERR_CODE  output  2  first error: 0 none, 1 not one-hot, 2 IDLE->PULSE skip, 3 backward step (PULSE->PRE_PULSE or PRE_PULSE->IDLE)
TOO_LONG  output  1  sticky pulse-overlength flag (optional feature)

Behaviour:
- Interface: one clock CLK; reset RST is synchronous, active-high.
- Reset values: PULSE_CNT=0, LAST_WIDTH=0, WIDTH_VALID=0, SEQ_ERR=0, ERR_CODE=0, TOO_LONG=0, input register=3'b000, FSM=S_WAIT, width counter=0.
- Input stage: {IDLE,PRE_PULSE,PULSE} registered once (in_q). All checks use in_q. Outputs update one edge after in_q. Total latency from input change to output is 2 clocks.
- FSM states: S_WAIT, S_IDLE, S_PRE, S_PULSE.
- S_WAIT: no checks performed. Goes to S_IDLE when in_q == IDLE-only. Any other in_q value stays in S_WAIT with no error.
- In S_IDLE/S_PRE/S_PULSE, error checks apply in priority order:
  - in_q not exactly one-hot -> code 1.
  - S_IDLE seeing PULSE -> code 2.
  - S_PRE seeing IDLE, or S_PULSE seeing PRE_PULSE -> code 3.
- Legal transitions: S_IDLE->S_IDLE, S_IDLE->S_PRE, S_PRE->S_PRE, S_PRE->S_PULSE, S_PULSE->S_PULSE, S_PULSE->S_IDLE.
- On any error: SEQ_ERR<=1. ERR_CODE loads only if SEQ_ERR was 0 (first error held). FSM -> S_WAIT. Width counter cleared. No WIDTH_VALID, no PULSE_CNT increment.
- Width counter:
  - Loads 1 on S_PRE->S_PULSE.
  - Increments each cycle in S_PULSE.
  - Saturates at 2^WIDTH_W-1.
- Pulse completion (S_PULSE->S_IDLE):
  - LAST_WIDTH<=width counter.
  - WIDTH_VALID=1 for exactly that one cycle.
  - PULSE_CNT<=PULSE_CNT+1, wrapping from 2^CNT_W-1 to 0.
- CLR_ERR: clears SEQ_ERR, ERR_CODE, TOO_LONG next edge. If a new error is detected in the same cycle, the new error wins: SEQ_ERR=1, ERR_CODE=new code. Does not affect counters or FSM.
- RST mid-pulse: all state returns to reset values. The interrupted pulse is not counted, and no WIDTH_VALID is generated.

Optional Feature:
PULSE_MON_MAXCHK_EN
- Defined: when the width counter in S_PULSE exceeds MAX_PULSE, TOO_LONG<=1 (sticky until CLR_ERR/RST). Counting and width measurement are unaffected. SEQ_ERR is not set.
- Undefined: TOO_LONG tied to 0; no compare logic generated.

Test Plan:
- RST=1 for 5 clocks, then inputs IDLE=1 only -> all outputs 0, FSM reaches S_IDLE, no error.
- Sequence IDLE x3, PRE_PULSE x2, PULSE x3, IDLE -> WIDTH_VALID single-cycle strobe 2 clocks after PULSE falls, LAST_WIDTH=3, PULSE_CNT=1.
- From S_IDLE drive PULSE=1 directly -> SEQ_ERR=1, ERR_CODE=2. Then drive {1,1,0} -> ERR_CODE stays 2 (first error held).
- Drive IDLE=PRE_PULSE=PULSE=0 while in S_PRE -> ERR_CODE=1. Assert CLR_ERR with legal IDLE -> SEQ_ERR=0, ERR_CODE=0, FSM resyncs and next full pulse counts normally.
- CNT_W=4: run 17 legal pulses of width 1 -> PULSE_CNT wraps to 1. WIDTH_W=3 with a 10-cycle PULSE -> LAST_WIDTH=7 (saturated).
- With PULSE_MON_MAXCHK_EN, MAX_PULSE=4: PULSE width 4 -> TOO_LONG=0. PULSE width 5 -> TOO_LONG=1, SEQ_ERR=0. Assert RST mid-pulse -> PULSE_CNT unchanged at 0 and no WIDTH_VALID.

Source files
------------

// File: rtl/pulse_monitor_if.sv
// Signal bundle between the pulse-transition FSM (master side) and pulse_monitor (slave side).
interface pulse_monitor_if #(
  parameter int CNT_W   = 16,
  parameter int WIDTH_W = 8
);
  logic               IDLE;
  logic               PRE_PULSE;
  logic               PULSE;
  logic               CLR_ERR;
  logic [CNT_W-1:0]   PULSE_CNT;
  logic [WIDTH_W-1:0] LAST_WIDTH;
  logic               WIDTH_VALID;
  logic               SEQ_ERR;
  logic [1:0]         ERR_CODE;
  logic               TOO_LONG;

  modport master (
    output IDLE, PRE_PULSE, PULSE, CLR_ERR,
    input  PULSE_CNT, LAST_WIDTH, WIDTH_VALID, SEQ_ERR, ERR_CODE, TOO_LONG
  );

  modport slave (
    input  IDLE, PRE_PULSE, PULSE, CLR_ERR,
    output PULSE_CNT, LAST_WIDTH, WIDTH_VALID, SEQ_ERR, ERR_CODE, TOO_LONG
  );
endinterface

// File: rtl/pulse_monitor.sv
// Checks IDLE -> PRE_PULSE -> PULSE -> IDLE sequencing, measures pulse widths and counts pulses.
// Optional pulse-overlength flag enabled by defining PULSE_MON_MAXCHK_EN.
module pulse_monitor #(
  parameter int CNT_W     = 16,
  parameter int WIDTH_W   = 8,
  parameter int MAX_PULSE = 4
) (
  input logic             CLK,
  input logic             RST,
  pulse_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_PRE   = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  localparam logic [2:0]         V_IDLE    = 3'b100;
  localparam logic [2:0]         V_PRE     = 3'b010;
  localparam logic [2:0]         V_PULSE   = 3'b001;
  localparam logic [WIDTH_W-1:0] WIDTH_ONE = {{(WIDTH_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = {WIDTH_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == V_IDLE) || (v == V_PRE) || (v == V_PULSE);
  endfunction

  logic [2:0]         in_q_r;
  state_t             state_r, state_s;
  logic [WIDTH_W-1:0] width_r, width_s;
  logic [CNT_W-1:0]   pulse_cnt_r;
  logic [WIDTH_W-1:0] last_width_r;
  logic               width_valid_r;
  logic               seq_err_r;
  logic [1:0]         err_code_r;
  logic               err_s;
  logic [1:0]         code_s;
  logic               done_s;

  // Sequence checker: error detection in priority order, then legal transitions and width counting
  always_comb begin
    state_s = state_r;
    width_s = width_r;
    err_s   = 1'b0;
    code_s  = 2'd0;
    done_s  = 1'b0;
    case (state_r)
      S_WAIT: begin
        if (in_q_r == V_IDLE) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      default: begin
        if (!is_onehot3(in_q_r)) begin
          err_s   = 1'b1;
          code_s  = 2'd1;
          state_s = S_WAIT;
          width_s = '0;
        end else if ((state_r == S_IDLE) && (in_q_r == V_PULSE)) begin
          err_s   = 1'b1;
          code_s  = 2'd2;
          state_s = S_WAIT;
          width_s = '0;
        end else if (((state_r == S_PRE) && (in_q_r == V_IDLE)) ||
                     ((state_r == S_PULSE) && (in_q_r == V_PRE))) begin
          err_s   = 1'b1;
          code_s  = 2'd3;
          state_s = S_WAIT;
          width_s = '0;
        end else begin
          // Only one-hot values legal for the current state reach here
          case (state_r)
            S_IDLE: begin
              if (in_q_r == V_PRE) begin
                state_s = S_PRE;
              end else begin
                state_s = S_IDLE;
              end
            end
            S_PRE: begin
              if (in_q_r == V_PULSE) begin
                state_s = S_PULSE;
                width_s = WIDTH_ONE;
              end else begin
                state_s = S_PRE;
              end
            end
            S_PULSE: begin
              if (in_q_r == V_IDLE) begin
                state_s = S_IDLE;
                done_s  = 1'b1;
                width_s = '0;
              end else if (width_r == WIDTH_MAX) begin
                width_s = WIDTH_MAX;
              end else begin
                width_s = width_r + WIDTH_ONE;
              end
            end
            default: begin
              state_s = S_WAIT;
            end
          endcase
        end
      end
    endcase
  end

  // Input stage, FSM, width counter and reporting registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_q_r        <= 3'b000;
      state_r       <= S_WAIT;
      width_r       <= '0;
      pulse_cnt_r   <= '0;
      last_width_r  <= '0;
      width_valid_r <= 1'b0;
      seq_err_r     <= 1'b0;
      err_code_r    <= 2'd0;
    end else begin
      in_q_r        <= {bus.IDLE, bus.PRE_PULSE, bus.PULSE};
      state_r       <= state_s;
      width_r       <= width_s;
      width_valid_r <= done_s;
      if (done_s) begin
        last_width_r <= width_r;
        pulse_cnt_r  <= pulse_cnt_r + CNT_ONE;
      end
      // A fresh error beats a simultaneous clear; otherwise the first code is held
      if (err_s) begin
        seq_err_r <= 1'b1;
        if (!seq_err_r || bus.CLR_ERR) begin
          err_code_r <= code_s;
        end
      end else if (bus.CLR_ERR) begin
        seq_err_r  <= 1'b0;
        err_code_r <= 2'd0;
      end
    end
  end

  assign bus.PULSE_CNT   = pulse_cnt_r;
  assign bus.LAST_WIDTH  = last_width_r;
  assign bus.WIDTH_VALID = width_valid_r;
  assign bus.SEQ_ERR     = seq_err_r;
  assign bus.ERR_CODE    = err_code_r;

`ifdef PULSE_MON_MAXCHK_EN
  logic too_long_r;
  logic too_long_set_s;

  assign too_long_set_s = (state_r == S_PULSE) && (32'(width_r) > 32'(MAX_PULSE));

  // Sticky overlength flag, independent of sequencing errors
  always_ff @(posedge CLK) begin
    if (RST) begin
      too_long_r <= 1'b0;
    end else if (too_long_set_s) begin
      too_long_r <= 1'b1;
    end else if (bus.CLR_ERR) begin
      too_long_r <= 1'b0;
    end
  end

  assign bus.TOO_LONG = too_long_r;
`else
  // MAX_PULSE has no effect without the overlength check
  if (MAX_PULSE < 0) begin : g_max_pulse_unused
  end

  assign bus.TOO_LONG = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_monitor.sv
// Scoreboard bench for pulse_monitor: directed sequences push expected width strobes, a monitor pops them.
module tb_pulse_monitor;
  localparam int CNT_W     = 4;
  localparam int WIDTH_W   = 3;
  localparam int MAX_PULSE = 4;
`ifdef PULSE_MON_MAXCHK_EN
  localparam logic MAXCHK = 1'b1;
`else
  localparam logic MAXCHK = 1'b0;
`endif
  localparam logic [2:0] V_IDLE  = 3'b100;
  localparam logic [2:0] V_PRE   = 3'b010;
  localparam logic [2:0] V_PULSE = 3'b001;

  typedef struct {
    int width;
    int cnt;
    int cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  pulse_monitor_if #(.CNT_W(CNT_W), .WIDTH_W(WIDTH_W)) bus ();

  pulse_monitor #(.CNT_W(CNT_W), .WIDTH_W(WIDTH_W), .MAX_PULSE(MAX_PULSE)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      {bus.IDLE, bus.PRE_PULSE, bus.PULSE} = v;
      bus.CLR_ERR = clr;
      @(posedge CLK);
      #1;
    end
    bus.CLR_ERR = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(V_IDLE, 5, 1'b0);
    RST = 1'b0;
    exp_cnt = 0;
  endtask

  // Legal pulse of width w; the strobe is due two edges after IDLE is driven
  task automatic pulse(input int w);
    exp_t e;
    drive(V_IDLE, 1, 1'b0);
    drive(V_PRE, 2, 1'b0);
    drive(V_PULSE, w, 1'b0);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    e.width = (w > 7) ? 7 : w;
    e.cnt   = exp_cnt;
    e.cyc   = cyc + 2;
    sb_q.push_back(e);
    drive(V_IDLE, 1, 1'b0);
  endtask

  task automatic chk_err(input string name, input logic s, input logic [1:0] c);
    chk({name, "_seq_err"}, 32'(bus.SEQ_ERR), 32'(s));
    chk({name, "_err_code"}, 32'(bus.ERR_CODE), 32'(c));
  endtask

  // Monitor: every WIDTH_VALID strobe must match the oldest expected completion
  always @(negedge CLK) begin : mon
    exp_t e;
    if (bus.WIDTH_VALID === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got WIDTH_VALID=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("last_width", 32'(bus.LAST_WIDTH), e.width);
        chk("pulse_cnt", 32'(bus.PULSE_CNT), e.cnt);
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    {bus.IDLE, bus.PRE_PULSE, bus.PULSE} = V_IDLE;
    bus.CLR_ERR = 1'b0;
    do_reset();
    chk("rst_pulse_cnt", 32'(bus.PULSE_CNT), 0);
    chk("rst_last_width", 32'(bus.LAST_WIDTH), 0);
    chk("rst_width_valid", 32'(bus.WIDTH_VALID), 0);
    chk("rst_too_long", 32'(bus.TOO_LONG), 0);
    chk_err("rst", 1'b0, 2'd0);
    drive(V_IDLE, 3, 1'b0);
    chk_err("idle_sync", 1'b0, 2'd0);

    // Basic width-3 pulse
    pulse(3);
    drive(V_IDLE, 1, 1'b0);
    chk("p3_cnt", 32'(bus.PULSE_CNT), 1);
    chk("p3_width", 32'(bus.LAST_WIDTH), 3);

    // IDLE->PULSE skip, then a not-one-hot error that must not overwrite the first code
    drive(V_PULSE, 1, 1'b0);
    drive(V_IDLE, 1, 1'b0);
    chk_err("skip", 1'b1, 2'd2);
    drive(3'b110, 1, 1'b0);
    drive(V_IDLE, 2, 1'b0);
    chk_err("first_held", 1'b1, 2'd2);

    drive(V_IDLE, 1, 1'b1);
    chk_err("clr1", 1'b0, 2'd0);

    // All-zero input while in S_PRE
    drive(V_PRE, 1, 1'b0);
    drive(3'b000, 1, 1'b0);
    drive(V_IDLE, 1, 1'b0);
    chk_err("zero_in_pre", 1'b1, 2'd1);

    // Backward step coinciding with CLR_ERR: new code wins
    drive(V_IDLE, 1, 1'b0);
    drive(V_PRE, 1, 1'b0);
    drive(V_IDLE, 1, 1'b0);
    drive(V_IDLE, 1, 1'b1);
    chk_err("clr_vs_err", 1'b1, 2'd3);

    drive(V_IDLE, 1, 1'b1);
    chk_err("clr2", 1'b0, 2'd0);
    pulse(2);
    drive(V_IDLE, 1, 1'b0);
    chk("resync_cnt", 32'(bus.PULSE_CNT), 2);

    // Width saturation at 7
    pulse(10);
    drive(V_IDLE, 1, 1'b0);
    chk("sat_width", 32'(bus.LAST_WIDTH), 7);
    chk("sat_too_long", 32'(bus.TOO_LONG), 32'(MAXCHK));
    chk_err("sat", 1'b0, 2'd0);
    drive(V_IDLE, 1, 1'b1);

    // Counter wrap: 17 pulses from reset leave the count at 1
    do_reset();
    for (int i = 0; i < 17; i++) pulse(1);
    drive(V_IDLE, 1, 1'b0);
    chk("wrap_cnt", 32'(bus.PULSE_CNT), 1);

    // Overlength boundary
    pulse(4);
    drive(V_IDLE, 1, 1'b0);
    chk("len4_too_long", 32'(bus.TOO_LONG), 0);
    pulse(5);
    drive(V_IDLE, 1, 1'b0);
    chk("len5_too_long", 32'(bus.TOO_LONG), 32'(MAXCHK));
    chk_err("len5", 1'b0, 2'd0);

    // Reset in the middle of a pulse: nothing counted, no strobe
    do_reset();
    drive(V_IDLE, 1, 1'b0);
    drive(V_PRE, 2, 1'b0);
    drive(V_PULSE, 2, 1'b0);
    RST = 1'b1;
    drive(V_PULSE, 1, 1'b0);
    RST = 1'b0;
    drive(V_IDLE, 4, 1'b0);
    chk("midrst_cnt", 32'(bus.PULSE_CNT), 0);
    chk("midrst_width", 32'(bus.LAST_WIDTH), 0);
    chk("midrst_too_long", 32'(bus.TOO_LONG), 0);
    chk_err("midrst", 1'b0, 2'd0);

    drive(V_IDLE, 3, 1'b0);
    chk("pending_strobes", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
